fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   IF stage plus IF/ID pipeline register of the 5-stage MIPS core. Holds the PC,
//   drives the instruction-memory address, and registers the fetched word, its PC
//   and its link address into ID. Branch/jump redirects are resolved in ID with one
//   architectural delay slot and no flush. The hazard unit's stall freezes the stage.
// PARAMETERS
//   PC_RESET   32'h0000_3000  PC value loaded on reset (text segment base)
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   stall      in   1   from hazard unit; 1 = hold PC and the IF/ID register
//   npc_sel    in   2   next-PC source decoded from instr_d by ID control (package enum)
//   br_cond    in   1   ID branch compare result, computed on forwarded operands
//   jr_target  in   32  forwarded rs value in ID, used for jr/jalr
//   instr_f    in   32  word returned by instruction memory for pc_f (combinational read)
//   pc_f       out  32  current fetch address to instruction memory
//   instr_d    out  32  registered instruction in ID
//   pc_d       out  32  PC of instr_d
//   pc8_d      out  32  pc_d + 8, link address for jal/jalr
//   valid_d    out  1   0 = ID holds reset bubble; 1 = ID holds a fetched instruction
// BEHAVIOUR
//   - Clock/reset: single clock; reset is asynchronous and active-high.
//   - Reset: takes effect immediately, whatever stall is. pc_f=PC_RESET,
//     instr_d=32'h0 (nop), pc_d=32'h0, pc8_d=32'h0, valid_d=0.
//   - Edge with stall=0: pc_f<=npc; instr_d<=instr_f; pc_d<=pc_f;
//     pc8_d<=pc_f+8; valid_d<=1.
//   - Edge with stall=1: every register holds, including pc_f. A pending redirect
//     is not lost: npc_sel, br_cond and jr_target are re-evaluated each cycle and
//     applied on the first non-stalled edge.
//   - npc (combinational), all sums modulo 2^32:
//       NPC_SEQ : pc_f + 4
//       NPC_BR  : br_cond ? pc_d + 4 + (sext(instr_d[15:0]) << 2) : pc_f + 4
//       NPC_J   : {pc_d_plus4[31:28], instr_d[25:0], 2'b00}
//       NPC_JR  : {jr_target[31:2], 2'b00}
//   - When valid_d=0, npc_sel is ignored and npc = pc_f + 4.
//   - Delay slot: when a redirect is in ID, pc_f = pc_d+4. That delay-slot word is
//     latched into ID on the same edge the redirect is taken, and it always executes.
//     Target fetch happens in the following cycle. No squash.
//   - Latency: instr_f appears on instr_d one edge after pc_f presents its address.
//     A redirect decided in ID cycle N puts the target on pc_f in cycle N+1.
//   - Wrap-around: pc_f = 32'hFFFF_FFFC with NPC_SEQ gives 32'h0000_0000.
//     pc8_d wraps the same way. No error flag.
//   - Memory indexing: instruction memory uses pc_f[11:2]. This block never
//     range-checks pc_f.
// STRUCTURE
//   - Shared package cpu_defs: NPC_SEQ=2'd0, NPC_BR=2'd1, NPC_J=2'd2, NPC_JR=2'd3;
//     PC_RESET_DEFAULT=32'h0000_3000; NOP=32'h0.
//   - One sub-module npc_gen: purely combinational next-PC mux, with inputs
//     pc_f, pc_d, instr_d, npc_sel, br_cond, jr_target and valid_d.
//   - The top level holds the PC register and the IF/ID register with stall enable.
// TESTING
//   1 Reset: assert reset mid-cycle while stall=1 -> pc_f=32'h3000 immediately
//     (before the next edge); instr_d=0, valid_d=0.
//   2 Sequential: reset release, stall=0, npc_sel=SEQ for 3 edges -> pc_f
//     3004/3008/300C; pc_d lags pc_f by one edge; pc8_d=pc_d+8;
//     instr_d=previous instr_f.
//   3 beq: instr_d=32'h1000FFFF, pc_d=32'h3004, npc_sel=BR.
//     br_cond=1 -> next pc_f=32'h3004. br_cond=0 -> next pc_f=32'h300C.
//     Delay-slot word from 32'h3008 is in ID after that edge.
//   4 jal: instr_d=32'h0C000C10 at pc_d=32'h3000, npc_sel=J -> next pc_f=32'h3040;
//     pc8_d=32'h3008 while jal is in ID.
//   5 Stall over redirect: npc_sel=BR, br_cond=1, stall=1 for 2 edges -> pc_f,
//     instr_d and pc_d unchanged. First edge with stall=0 -> pc_f=branch target.
//   6 jr/wrap: jr_target=32'h0000_3103, npc_sel=JR -> pc_f=32'h3100.
//     Force pc_f=32'hFFFF_FFFC, npc_sel=SEQ -> next pc_f=32'h0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: next-PC source encoding, reset PC and the nop word.
package cpu_defs;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // Sign-extended word offset of a branch immediate, already scaled to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard/ID control and imem data in, fetch address and IF/ID contents out.
interface fetch_unit_if;
  import cpu_defs::*;

  logic        stall;
  npc_sel_e    npc_sel;
  logic        br_cond;
  logic [31:0] jr_target;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;

  modport master (
    output stall, npc_sel, br_cond, jr_target, instr_f,
    input  pc_f, instr_d, pc_d, pc8_d, valid_d
  );

  modport slave (
    input  stall, npc_sel, br_cond, jr_target, instr_f,
    output pc_f, instr_d, pc_d, pc8_d, valid_d
  );

endinterface

// File: rtl/npc_gen.sv
// Combinational next-PC mux; redirects come from the instruction held in ID (one delay slot).
module npc_gen
  import cpu_defs::*;
(
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_d,
  input  logic [31:0] i_instr_d,
  input  npc_sel_e    i_npc_sel,
  input  logic        i_br_cond,
  input  logic [31:0] i_jr_target,
  input  logic        i_valid_d,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc_f_plus4;
  logic [31:0] w_pc_d_plus4;

  assign w_pc_f_plus4 = i_pc_f + 32'd4;
  assign w_pc_d_plus4 = i_pc_d + 32'd4;

  always_comb begin
    o_npc = w_pc_f_plus4;
    // A reset bubble in ID carries no decoded control, so its npc_sel is meaningless.
    if (i_valid_d) begin
      unique case (i_npc_sel)
        NPC_SEQ: o_npc = w_pc_f_plus4;
        NPC_BR:  o_npc = i_br_cond ? (w_pc_d_plus4 + br_offset(i_instr_d[15:0]))
                                   : w_pc_f_plus4;
        NPC_J:   o_npc = (w_pc_d_plus4 & 32'hF000_0000)
                       | ((i_instr_d << 2) & 32'h0FFF_FFFC);
        NPC_JR:  o_npc = i_jr_target & 32'hFFFF_FFFC;
        default: o_npc = w_pc_f_plus4;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register: PC register, fetch address, and the fetched word with its PC and link address.
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc8_d;
  logic        r_valid_d;
  logic [31:0] w_npc;

  npc_gen u_npc_gen (
    .i_pc_f      (r_pc_f),
    .i_pc_d      (r_pc_d),
    .i_instr_d   (r_instr_d),
    .i_npc_sel   (bus.npc_sel),
    .i_br_cond   (bus.br_cond),
    .i_jr_target (bus.jr_target),
    .i_valid_d   (r_valid_d),
    .o_npc       (w_npc)
  );

  // Stall freezes everything; the redirect inputs stay live so it is taken on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f    <= PC_RESET;
      r_instr_d <= NOP;
      r_pc_d    <= 32'h0;
      r_pc8_d   <= 32'h0;
      r_valid_d <= 1'b0;
    end else if (!bus.stall) begin
      r_pc_f    <= w_npc;
      r_instr_d <= bus.instr_f;
      r_pc_d    <= r_pc_f;
      r_pc8_d   <= r_pc_f + 32'd8;
      r_valid_d <= 1'b1;
    end
  end

  assign bus.pc_f    = r_pc_f;
  assign bus.instr_d = r_instr_d;
  assign bus.pc_d    = r_pc_d;
  assign bus.pc8_d   = r_pc8_d;
  assign bus.valid_d = r_valid_d;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written stall/jal sequences, random run against a reference model.
module tb_fetch_unit;
  import cpu_defs::*;

  logic clk;
  logic reset;
  logic [31:0] imem [0:1023];
  int checks = 0;
  int errors = 0;

  fetch_unit_if fif ();

  fetch_unit #(.PC_RESET(32'h0000_3000)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fif)
  );

  assign fif.instr_f = imem[fif.pc_f[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    npc_sel_e    sel;
    logic        br;
    logic [31:0] jr;
    logic [31:0] e_pc_f;
    logic [31:0] e_pc_d;
    logic [31:0] e_pc8_d;
    logic [31:0] e_instr_d;
    logic        e_valid;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pcf, input logic [31:0] ins,
                         input logic [31:0] pcd, input logic [31:0] pc8, input logic v);
    chk({tag, ".pc_f"},    fif.pc_f,    pcf);
    chk({tag, ".instr_d"}, fif.instr_d, ins);
    chk({tag, ".pc_d"},    fif.pc_d,    pcd);
    chk({tag, ".pc8_d"},   fif.pc8_d,   pc8);
    chk({tag, ".valid_d"}, {31'b0, fif.valid_d}, {31'b0, v});
  endtask

  task automatic drive(input logic st, input npc_sel_e s, input logic b, input logic [31:0] j);
    fif.stall     = st;
    fif.npc_sel   = s;
    fif.br_cond   = b;
    fif.jr_target = j;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, NPC_SEQ, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference next PC, straight from the architectural rules.
  function automatic logic [31:0] model_npc(input npc_sel_e s, input logic b, input logic [31:0] j,
                                            input logic [31:0] pc, input logic [31:0] id_pc,
                                            input logic [31:0] id_ins, input logic valid);
    logic [31:0] off;
    logic [31:0] idx;
    off = 32'($signed(id_ins[15:0])) * 32'd4;
    idx = {6'b0, id_ins[25:0]};
    if (!valid) return pc + 32'd4;
    case (s)
      NPC_BR:  return b ? id_pc + 32'd4 + off : pc + 32'd4;
      NPC_J:   return ((id_pc + 32'd4) & 32'hF000_0000) + idx * 32'd4;
      NPC_JR:  return j - (j % 32'd4);
      default: return pc + 32'd4;
    endcase
  endfunction

  logic [31:0] m_pc, m_id_ins, m_id_pc, m_npc;
  logic        m_valid;
  logic        r_st, r_br;
  npc_sel_e    r_sel;
  logic [31:0] r_jr;

  initial begin
    reset = 1'b0;
    drive(1'b0, NPC_SEQ, 1'b0, 32'h0);
    for (int i = 0; i < 1024; i++) imem[i] = 32'h2400_0000 | i;
    imem[0] = 32'h0C00_0C10;
    imem[1] = 32'h1000_FFFF;

    // Asynchronous reset mid-cycle while stalled.
    #12;
    fif.stall = 1'b1;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_all("reset_held", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    vt[0] = '{1'b0, NPC_J,   1'b1, 32'h0,        32'h3004,     32'h3000,     32'h3008, 32'h0C00_0C10, 1'b1};
    vt[1] = '{1'b0, NPC_SEQ, 1'b0, 32'h0,        32'h3008,     32'h3004,     32'h300C, 32'h1000_FFFF, 1'b1};
    vt[2] = '{1'b0, NPC_BR,  1'b1, 32'h0,        32'h3004,     32'h3008,     32'h3010, 32'h2400_0002, 1'b1};
    vt[3] = '{1'b0, NPC_SEQ, 1'b0, 32'h0,        32'h3008,     32'h3004,     32'h300C, 32'h1000_FFFF, 1'b1};
    vt[4] = '{1'b0, NPC_BR,  1'b0, 32'h0,        32'h300C,     32'h3008,     32'h3010, 32'h2400_0002, 1'b1};
    vt[5] = '{1'b1, NPC_SEQ, 1'b0, 32'h0,        32'h300C,     32'h3008,     32'h3010, 32'h2400_0002, 1'b1};
    vt[6] = '{1'b0, NPC_JR,  1'b0, 32'h3103,     32'h3100,     32'h300C,     32'h3014, 32'h2400_0003, 1'b1};
    vt[7] = '{1'b0, NPC_JR,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h3100,   32'h3108, 32'h2400_0040, 1'b1};
    vt[8] = '{1'b0, NPC_SEQ, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h4,   32'h2400_03FF, 1'b1};
    vt[9] = '{1'b0, NPC_SEQ, 1'b0, 32'h0,        32'h4,        32'h0,        32'h8,    32'h0C00_0C10, 1'b1};

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].stall, vt[i].sel, vt[i].br, vt[i].jr);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_pc_f, vt[i].e_instr_d, vt[i].e_pc_d,
              vt[i].e_pc8_d, vt[i].e_valid);
    end

    // jal in ID: link address visible, then jump target fetched.
    do_reset();
    step();
    chk("jal.pc8_d", fif.pc8_d, 32'h3008);
    chk("jal.instr_d", fif.instr_d, 32'h0C00_0C10);
    drive(1'b0, NPC_J, 1'b0, 32'h0);
    step();
    chk("jal.target", fif.pc_f, 32'h3040);

    // Branch held in ID across a two-cycle stall, taken on release.
    do_reset();
    step();
    step();
    drive(1'b1, NPC_BR, 1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk_all($sformatf("stall%0d", k), 32'h3008, 32'h1000_FFFF, 32'h3004, 32'h300C, 1'b1);
    end
    fif.stall = 1'b0;
    step();
    chk_all("stall_release", 32'h3004, 32'h2400_0002, 32'h3008, 32'h3010, 1'b1);

    // Random run against the reference model.
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    do_reset();
    m_pc = 32'h3000; m_id_ins = 32'h0; m_id_pc = 32'h0; m_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r_st  = ($urandom_range(0, 3) == 0);
      r_sel = npc_sel_e'($urandom_range(0, 3));
      r_br  = $urandom_range(0, 1) == 1;
      r_jr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      drive(r_st, r_sel, r_br, r_jr);
      if (!r_st) begin
        m_npc    = model_npc(r_sel, r_br, r_jr, m_pc, m_id_pc, m_id_ins, m_valid);
        m_id_ins = imem[(m_pc / 4) % 1024];
        m_id_pc  = m_pc;
        m_valid  = 1'b1;
        m_pc     = m_npc;
      end
      step();
      chk_all($sformatf("rnd%0d", c), m_pc, m_id_ins, m_id_pc,
              m_valid ? m_id_pc + 32'd8 : 32'h0, m_valid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
